pll_reset_seq: RTL



---
 rtl/pll_reset_seq_pkg.sv | 31 +++
 rtl/sync2.sv | 29 ++
 rtl/pll_reset_seq.sv | 142 ++++++++++++++
 3 files changed

// File: rtl/pll_reset_seq_pkg.sv
// -----------------------------------------------------------------------------
// pll_reset_seq_pkg
//   Shared types and helpers for the PLL reset sequencer.
//   - pll_seq_state_t : sequencer states (PLL_RST, WAIT_LOCK, STABLE, RUN)
//   - timer_width()   : bit width of the single shared sequencing timer, sized
//                       so it can count from 0 up to max(...)-1
// -----------------------------------------------------------------------------
package pll_reset_seq_pkg;

   typedef enum logic [1:0] {
      PLL_RST   = 2'd0,
      WAIT_LOCK = 2'd1,
      STABLE    = 2'd2,
      RUN       = 2'd3
   } pll_seq_state_t;

   // $clog2 of the largest interval. Terminal compares are against N-1, so
   // $clog2(N) bits are always sufficient; a floor of 1 bit keeps the timer
   // legal when every interval is a single cycle.
   function automatic int timer_width(input int rst_cycles,
                                      input int lock_timeout,
                                      input int stable_cycles);
      int m;
      m = rst_cycles;
      if (lock_timeout > m) m = lock_timeout;
      if (stable_cycles > m) m = stable_cycles;
      if (m < 2) return 1;
      return $clog2(m);
   endfunction

endpackage

// File: rtl/sync2.sv
// -----------------------------------------------------------------------------
// sync2
//   Generic two-flop single-bit synchroniser with synchronous reset to 0.
//   Ports:
//     clk : destination clock
//     rst : synchronous active-high reset (both flops cleared)
//     d   : asynchronous input bit
//     q   : synchronised output, two destination edges after d is sampled
// -----------------------------------------------------------------------------
module sync2 (
   input  logic clk,
   input  logic rst,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk) begin
      if (rst) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/pll_reset_seq.sv
// -----------------------------------------------------------------------------
// pll_reset_seq
//   Reset sequencer for the system PLL, running on the free-running reference
//   clock. Pulses the PLL reset, waits for lock (retrying on timeout), qualifies
//   lock for STABLE_CYCLES consecutive cycles, then releases the system reset.
//   Loss of lock while running re-asserts the system reset and restarts.
//
//   Optional build macro: PLL_RESET_SEQ_STATS_EN
//     defined   : saturating timeout / lock-loss counters are built
//     undefined : no counter flops, both counter outputs tied to 0
//
//   Parameters:
//     RST_CYCLES    : cycles pll_rst is held per attempt (>=1)
//     LOCK_TIMEOUT  : cycles to wait for lock before retrying (>=1)
//     STABLE_CYCLES : consecutive synchronised-lock cycles before release (>=1)
//     CNT_W         : statistics counter width
//
//   Ports:
//     clk           : reference clock
//     rst           : synchronous active-high reset
//     locked        : PLL lock, asynchronous to clk
//     pll_rst       : reset to the PLL
//     sys_rst       : active-high system reset request
//     ready         : high while in RUN
//     lock_loss_cnt : lock losses observed in RUN (saturating)
//     timeout_cnt   : lock-wait timeouts (saturating)
// -----------------------------------------------------------------------------
module pll_reset_seq
   import pll_reset_seq_pkg::*;
#(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 50000,
   parameter int STABLE_CYCLES = 1024,
   parameter int CNT_W         = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             locked,
   output logic             pll_rst,
   output logic             sys_rst,
   output logic             ready,
   output logic [CNT_W-1:0] lock_loss_cnt,
   output logic [CNT_W-1:0] timeout_cnt
);

   localparam int TMR_W = timer_width(RST_CYCLES, LOCK_TIMEOUT, STABLE_CYCLES);

   localparam logic [TMR_W-1:0] RST_LAST     = TMR_W'(RST_CYCLES - 1);
   localparam logic [TMR_W-1:0] TIMEOUT_LAST = TMR_W'(LOCK_TIMEOUT - 1);
   localparam logic [TMR_W-1:0] STABLE_LAST  = TMR_W'(STABLE_CYCLES - 1);

   pll_seq_state_t   state;
   pll_seq_state_t   next_state;
   logic [TMR_W-1:0] timer;
   logic             locked_s;
   logic             next_pll_rst;
   logic             next_sys_rst;
   logic             next_ready;

   sync2 u_lock_sync (
      .clk (clk),
      .rst (rst),
      .d   (locked),
      .q   (locked_s)
   );

   // Next-state and next-output decode. Outputs are decoded from next_state
   // and registered, so they switch on the same edge as the state register.
   always_comb begin
      next_state = state;
      unique case (state)
         PLL_RST: begin
            if (timer == RST_LAST) next_state = WAIT_LOCK;
         end
         WAIT_LOCK: begin
            // Lock takes priority over a timeout landing in the same cycle.
            if (locked_s)                   next_state = STABLE;
            else if (timer == TIMEOUT_LAST) next_state = PLL_RST;
         end
         STABLE: begin
            // Any drop restarts qualification from zero via WAIT_LOCK.
            if (!locked_s)                 next_state = WAIT_LOCK;
            else if (timer == STABLE_LAST) next_state = RUN;
         end
         RUN: begin
            if (!locked_s) next_state = PLL_RST;
         end
         default: next_state = PLL_RST;
      endcase

      next_pll_rst = (next_state == PLL_RST);
      next_sys_rst = (next_state != RUN);
      next_ready   = (next_state == RUN);
   end

   // State, timer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= PLL_RST;
         timer   <= '0;
         pll_rst <= 1'b1;
         sys_rst <= 1'b1;
         ready   <= 1'b0;
      end else begin
         state   <= next_state;
         // RUN has no timed exit, so the timer is parked at 0 there.
         if ((next_state != state) || (state == RUN)) timer <= '0;
         else                                         timer <= timer + 1'b1;
         pll_rst <= next_pll_rst;
         sys_rst <= next_sys_rst;
         ready   <= next_ready;
      end
   end

`ifdef PLL_RESET_SEQ_STATS_EN
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == {CNT_W{1'b1}}) ? v : v + 1'b1;
   endfunction

   // A WAIT_LOCK->PLL_RST transition can only be a timeout; a RUN->PLL_RST
   // transition can only be a lock loss (rst is handled separately).
   logic timeout_hit;
   logic loss_hit;

   assign timeout_hit = (state == WAIT_LOCK) && (next_state == PLL_RST);
   assign loss_hit    = (state == RUN)       && (next_state == PLL_RST);

   always_ff @(posedge clk) begin
      if (rst) begin
         timeout_cnt   <= '0;
         lock_loss_cnt <= '0;
      end else begin
         if (timeout_hit) timeout_cnt   <= sat_inc(timeout_cnt);
         if (loss_hit)    lock_loss_cnt <= sat_inc(lock_loss_cnt);
      end
   end
`else
   assign timeout_cnt   = '0;
   assign lock_loss_cnt = '0;
`endif

endmodule
